// File: rtl/median_3x3_window_ctrl.sv
// median_3x3_window_ctrl
// Sequencer for the 3x3 median datapath. Counts input pixel position and drives
// the line-buffer write/address, the window shift and window-valid strobes, then
// flushes the last row+1 window positions so the filtered frame keeps the full
// IMG_WIDTH x IMG_HEIGHT size. Output tuser/tlast are delayed to line up with
// the sorter pipeline of the median core.
//
// Optional build macro: MEDIAN_CTRL_STATS_EN adds o_frame_cnt / o_err_cnt.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a start-of-frame pixel; non-tuser pixels dropped
// S_RUN   | accepting pixels of a frame, one strobe set per accept
// S_FLUSH | input stalled, W+1 window ticks drain the final neighbourhoods

module median_3x3_window_ctrl #(
   parameter int  IMG_WIDTH   = 12,
   parameter int  IMG_HEIGHT  = 12,
   parameter int  KERNEL_SIZE = 3,
   parameter int  PIPE_LAT    = 4,
   localparam int ADDR_W      = $clog2(IMG_WIDTH)
) (
   input  logic              i_clk,
   input  logic              i_aresetn,
   input  logic              s_axis_tvalid,
   input  logic              s_axis_tuser,
   input  logic              s_axis_tlast,
   output logic              s_axis_tready,
   output logic              o_lb_wr_en,
   output logic [ADDR_W-1:0] o_lb_addr,
   output logic              o_win_shift,
   output logic              o_win_valid,
   output logic              o_border,
   output logic              m_axis_tvalid,
   output logic              m_axis_tuser,
   output logic              m_axis_tlast,
   output logic              o_frame_err
`ifdef MEDIAN_CTRL_STATS_EN
  ,output logic [15:0]       o_frame_cnt,
   output logic [15:0]       o_err_cnt
`endif
);

   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam int FL_W  = $clog2(IMG_WIDTH + 1);
   localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   generate
      if (KERNEL_SIZE != 3) begin : g_bad_kernel
         $error("median_3x3_window_ctrl supports KERNEL_SIZE=3 only");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [FL_W-1:0]   fl_q, fl_d;
   logic [ADDR_W-1:0] kc_q;
   logic [ROW_W-1:0]  kr_q;

   logic              accept;
   logic              col_last;
   logic              row_last;
   logic              primed;
   logic              wr_d;
   logic              shift_d;
   logic              win_d;
   logic [ADDR_W-1:0] addr_d;
   logic              k_rst;
   logic              new_err;
   logic              clr_err;
   logic              win_first_q;
   logic              win_last_q;
   logic [2:0]        pipe_q [PIPE_LAT];

   assign accept   = s_axis_tvalid & s_axis_tready;
   assign col_last = (col_q == COL_LAST);
   assign row_last = (row_q == ROW_LAST);
   // A full neighbourhood exists once the pixel index reaches W+1.
   assign primed   = (row_q > ROW_W'(1)) || ((row_q == ROW_W'(1)) && (col_q != '0));

   // FSM state register and input position counters.
   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         fl_q    <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         fl_q    <= fl_d;
      end
   end

   // Next state, counter updates and the strobe set for the following cycle.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      fl_d    = fl_q;
      wr_d    = 1'b0;
      shift_d = 1'b0;
      win_d   = 1'b0;
      addr_d  = o_lb_addr;
      k_rst   = 1'b0;
      new_err = 1'b0;
      clr_err = 1'b0;
      case (state_q)
         S_IDLE, S_RUN: begin
            if (accept && s_axis_tuser) begin
               // Start (or restart) a frame with this pixel as p=0.
               state_d = S_RUN;
               wr_d    = 1'b1;
               shift_d = 1'b1;
               addr_d  = '0;
               col_d   = ADDR_W'(1);
               row_d   = '0;
               k_rst   = 1'b1;
               clr_err = 1'b1;
               new_err = s_axis_tlast | (state_q == S_RUN);
            end else if (accept && (state_q == S_RUN)) begin
               wr_d    = 1'b1;
               shift_d = 1'b1;
               addr_d  = col_q;
               win_d   = primed;
               new_err = s_axis_tlast ^ col_last;
               if (col_last) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
               if (col_last && row_last) begin
                  state_d = S_FLUSH;
                  row_d   = '0;
                  fl_d    = FL_W'(IMG_WIDTH);
               end
            end
         end
         S_FLUSH: begin
            shift_d = 1'b1;
            win_d   = 1'b1;
            addr_d  = col_q;
            col_d   = col_last ? '0 : col_q + 1'b1;
            if (fl_q == '0) begin
               state_d = S_IDLE;
            end else begin
               fl_d = fl_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output-pixel position k, advanced once per valid window.
   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         kc_q <= '0;
         kr_q <= '0;
      end else if (k_rst) begin
         kc_q <= '0;
         kr_q <= '0;
      end else if (win_d) begin
         if (kc_q == COL_LAST) begin
            kc_q <= '0;
            kr_q <= (kr_q == ROW_LAST) ? '0 : kr_q + 1'b1;
         end else begin
            kc_q <= kc_q + 1'b1;
         end
      end
   end

   // Registered strobes, border flag and output framing flags.
   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         s_axis_tready <= 1'b0;
         o_lb_wr_en    <= 1'b0;
         o_lb_addr     <= '0;
         o_win_shift   <= 1'b0;
         o_win_valid   <= 1'b0;
         o_border      <= 1'b0;
         win_first_q   <= 1'b0;
         win_last_q    <= 1'b0;
      end else begin
         s_axis_tready <= (state_d != S_FLUSH);
         o_lb_wr_en    <= wr_d;
         o_lb_addr     <= addr_d;
         o_win_shift   <= shift_d;
         o_win_valid   <= win_d;
         o_border      <= win_d & ((kc_q == '0) | (kc_q == COL_LAST) |
                                   (kr_q == '0) | (kr_q == ROW_LAST));
         win_first_q   <= win_d & (kc_q == '0) & (kr_q == '0);
         win_last_q    <= win_d & (kc_q == COL_LAST);
      end
   end

   // Sticky framing error: a new error in the same cycle beats the tuser clear.
   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         o_frame_err <= 1'b0;
      end else if (new_err) begin
         o_frame_err <= 1'b1;
      end else if (clr_err) begin
         o_frame_err <= 1'b0;
      end
   end

   // Delay line matching the sorter latency of the median core.
   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         for (int i = 0; i < PIPE_LAT; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= {o_win_valid, win_first_q, win_last_q};
         for (int i = 1; i < PIPE_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign m_axis_tvalid = pipe_q[PIPE_LAT-1][2];
   assign m_axis_tuser  = pipe_q[PIPE_LAT-1][1];
   assign m_axis_tlast  = pipe_q[PIPE_LAT-1][0];

`ifdef MEDIAN_CTRL_STATS_EN
   // Completed-frame and error-event counters, both free-running with wrap.
   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         o_frame_cnt <= '0;
         o_err_cnt   <= '0;
      end else begin
         if ((state_q == S_FLUSH) && (state_d == S_IDLE)) begin
            o_frame_cnt <= o_frame_cnt + 16'd1;
         end
         if (new_err) begin
            o_err_cnt <= o_err_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_median_3x3_window_ctrl.sv
// Bench for median_3x3_window_ctrl (W=H=12, PIPE_LAT=4). A pixel-index model
// predicts every strobe per cycle and schedules expected output beats by time;
// directed frames add literal checks on beat counts, flags and latency.

module tb_median_3x3_window_ctrl;

   localparam int W    = 12;
   localparam int H    = 12;
   localparam int PL   = 4;
   localparam int AW   = $clog2(W);
   localparam int NPIX = W * H;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0;
   logic          tready, lb_wr_en, win_shift, win_valid, border;
   logic [AW-1:0] lb_addr;
   logic          m_tvalid, m_tuser, m_tlast, frame_err;
`ifdef MEDIAN_CTRL_STATS_EN
   logic [15:0]   frame_cnt, err_cnt;
`endif

   always #5 clk = ~clk;

   median_3x3_window_ctrl #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(3), .PIPE_LAT(PL)
   ) dut (
      .i_clk(clk), .i_aresetn(rst_n),
      .s_axis_tvalid(tvalid), .s_axis_tuser(tuser), .s_axis_tlast(tlast),
      .s_axis_tready(tready), .o_lb_wr_en(lb_wr_en), .o_lb_addr(lb_addr),
      .o_win_shift(win_shift), .o_win_valid(win_valid), .o_border(border),
      .m_axis_tvalid(m_tvalid), .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
      .o_frame_err(frame_err)
`ifdef MEDIAN_CTRL_STATS_EN
     ,.o_frame_cnt(frame_cnt), .o_err_cnt(err_cnt)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   longint     edge_cnt = 0;
   int         m_mode;           // 0 idle, 1 receiving, 2 flushing
   int         m_p, m_fl;
   bit         m_ready, m_err, m_acc, m_new_err, m_clr;
   bit         e_wr, e_shift, e_win, e_border;
   int         e_addr;
   int         m_frames, m_errs;
   logic [1:0] exp_m [longint];  // key: edge after which beat is visible; {tuser,tlast}

   task automatic model_window(input int k);
      int r, c;
      r        = k / W;
      c        = k % W;
      e_win    = 1'b1;
      e_border = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
      exp_m[edge_cnt + PL] = {k == 0, c == W - 1};
   endtask

   task automatic model_pixel();
      e_wr    = 1'b1;
      e_shift = 1'b1;
      e_addr  = m_p % W;
      if (m_p >= W + 1) model_window(m_p - (W + 1));
      m_p++;
      if (m_p == NPIX) begin
         m_mode = 2;
         m_fl   = 0;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_p = 0; m_fl = 0; m_ready = 1'b0; m_err = 1'b0;
         e_wr = 1'b0; e_shift = 1'b0; e_win = 1'b0; e_border = 1'b0; e_addr = 0;
         m_frames = 0; m_errs = 0;
         exp_m.delete();
      end else begin
         edge_cnt++;
         m_acc     = tvalid && m_ready;
         e_wr      = 1'b0; e_shift = 1'b0; e_win = 1'b0; e_border = 1'b0;
         m_new_err = 1'b0; m_clr = 1'b0;
         if (m_acc && m_mode != 2 && tuser) begin
            m_new_err = tlast || (m_mode == 1);
            m_clr     = 1'b1;
            m_mode    = 1;
            m_p       = 0;
            model_pixel();
         end else if (m_acc && m_mode == 1) begin
            m_new_err = (tlast != ((m_p % W) == W - 1));
            model_pixel();
         end else if (m_mode == 2) begin
            e_shift = 1'b1;
            e_addr  = (NPIX + m_fl) % W;
            model_window(NPIX - (W + 1) + m_fl);
            m_fl++;
            if (m_fl == W + 1) begin
               m_mode = 0;
               m_frames++;
            end
         end
         if (m_new_err) begin
            m_err = 1'b1;
            m_errs++;
         end else if (m_clr) begin
            m_err = 1'b0;
         end
         m_ready = (m_mode != 2);
      end
   end

   // ---------------- per-cycle compare + statistics ----------------
   int     beats, tusers, tlasts, borders, rdy_low;
   longint first_m_edge, pix0_edge, last_present_edge;
   bit     mv;
   logic [1:0] mf;

   always @(negedge clk) begin
      if (rst_n) begin
         chk("tready", tready, m_ready);
         chk("lb_wr_en", lb_wr_en, e_wr);
         chk("win_shift", win_shift, e_shift);
         chk("win_valid", win_valid, e_win);
         if (e_shift) chk("lb_addr", lb_addr, e_addr);
         if (e_win) chk("border", border, e_border);
         if (exp_m.exists(edge_cnt)) begin
            mv = 1'b1; mf = exp_m[edge_cnt]; exp_m.delete(edge_cnt);
         end else begin
            mv = 1'b0; mf = 2'b00;
         end
         chk("m_tvalid", m_tvalid, mv);
         if (mv) begin
            chk("m_tuser", m_tuser, mf[1]);
            chk("m_tlast", m_tlast, mf[0]);
         end
         chk("frame_err", frame_err, m_err);
`ifdef MEDIAN_CTRL_STATS_EN
         chk("frame_cnt", frame_cnt, m_frames);
         chk("err_cnt", err_cnt, m_errs);
`endif
         if (m_tvalid) begin
            if (beats == 0) first_m_edge = edge_cnt;
            beats++;
            tusers += m_tuser;
            tlasts += m_tlast;
         end
         if (win_valid && border) borders++;
         if (!tready) rdy_low++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic clear_stats();
      @(posedge clk); #1;
      beats = 0; tusers = 0; tlasts = 0; borders = 0; rdy_low = 0; first_m_edge = -1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
      end
   endtask

   task automatic send_px(input bit tu, input bit tl, input int gap);
      int guard;
      if (gap > 0) idle(gap);
      @(negedge clk);
      tvalid = 1'b1; tuser = tu; tlast = tl;
      guard = 0;
      while (!tready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) chk("tready_wait_timeout", 0, 1);
      last_present_edge = edge_cnt;
   endtask

   task automatic send_frame(input int gap_pct, input int bad_p, input int stop_p);
      int gap;
      for (int p = 0; p < NPIX; p++) begin
         if (p == stop_p) break;
         gap = (gap_pct > 0 && $urandom_range(99) < gap_pct) ? 1 : 0;
         send_px(p == 0, ((p % W) == W - 1) || (p == bad_p), gap);
         if (p == 0) pix0_edge = last_present_edge;
      end
   endtask

   task automatic frame_literals(input string tag);
      chk({tag, "_beats"}, beats, 144);
      chk({tag, "_tusers"}, tusers, 1);
      chk({tag, "_tlasts"}, tlasts, 12);
      chk({tag, "_borders"}, borders, 44);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_tready"}, tready, 0);
      chk({tag, "_wr_en"}, lb_wr_en, 0);
      chk({tag, "_addr"}, lb_addr, 0);
      chk({tag, "_shift"}, win_shift, 0);
      chk({tag, "_winv"}, win_valid, 0);
      chk({tag, "_border"}, border, 0);
      chk({tag, "_mvalid"}, m_tvalid, 0);
      chk({tag, "_muser"}, m_tuser, 0);
      chk({tag, "_mlast"}, m_tlast, 0);
      chk({tag, "_err"}, frame_err, 0);
   endtask

`ifdef MEDIAN_CTRL_STATS_EN
   int fc0, ec0;
`endif

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 check_all_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("tready_after_reset", tready, 1);

      // pixels without tuser while idle are dropped
      send_px(0, 0, 0);
      send_px(0, 1, 0);
      idle(4);
      chk("idle_drop_err", frame_err, 0);

      // 1: continuous frame
      clear_stats();
      send_frame(0, -1, -1);
      idle(40);
      frame_literals("t1");
      chk("t1_tready_low", rdy_low, 13);
      chk("t1_first_beat_latency", first_m_edge - pix0_edge, 18);

      // 2: 50% tvalid gaps
      clear_stats();
      send_frame(50, -1, -1);
      idle(40);
      frame_literals("t2");
      chk("t2_tready_low", rdy_low, 13);

      // 3: extra tlast at col 5 of row 2
      clear_stats();
      send_frame(0, 2 * W + 5, -1);
      idle(40);
      chk("t3_err_held", frame_err, 1);
      chk("t3_beats", beats, 144);

      // 4: tuser arrives at p=70
      send_frame(0, -1, 70);
      idle(10);
      chk("t4_err_cleared_by_tuser", frame_err, 0);
      clear_stats();
      send_frame(0, -1, -1);
      idle(40);
      chk("t4_err_set", frame_err, 1);
      chk("t4_beats", beats, 144);
      chk("t4_tusers", tusers, 1);
      chk("t4_tlasts", tlasts, 12);

      // 5: reset during FLUSH
      send_frame(0, -1, -1);
      idle(1);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("t5_reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      clear_stats();
      idle(25);
      chk("t5_no_partial_output", beats, 0);
      clear_stats();
      send_frame(0, -1, -1);
      idle(40);
      frame_literals("t5");
      chk("t5_tready_low", rdy_low, 13);
      chk("t5_first_beat_latency", first_m_edge - pix0_edge, 18);

`ifdef MEDIAN_CTRL_STATS_EN
      // 6: three frames, one framing error
      fc0 = frame_cnt;
      ec0 = err_cnt;
      send_frame(0, -1, -1);
      send_frame(0, 3 * W + 4, -1);
      send_frame(0, -1, -1);
      idle(40);
      chk("t6_frame_cnt", frame_cnt - fc0, 3);
      chk("t6_err_cnt", err_cnt - ec0, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
